// File: rtl/btb_pkg.sv
// Shared definitions for the branch target buffer: default geometry,
// entry/debug layouts and the install victim-selection helper.
package btb_pkg;

    localparam int DFLT_BTB_SETS     = 16;
    localparam int DFLT_BTB_TAG_BITS = 10;
    localparam int DFLT_BTB_IDX_BITS = $clog2(DFLT_BTB_SETS);
    localparam int DFLT_STAT_BITS    = 16;

    localparam logic WAY0 = 1'b0;
    localparam logic WAY1 = 1'b1;

    typedef struct packed {
        logic                         valid;
        logic [DFLT_BTB_TAG_BITS-1:0] tag;
        logic [31:0]                  target;
    } btb_entry_t;

    typedef struct packed {
        btb_entry_t [1:0] way;
        logic             lru;
    } btb_set_state_t;

    typedef btb_set_state_t [DFLT_BTB_SETS-1:0] btb_debug_t;

    // An empty way is always preferred over evicting a live entry.
    function automatic logic victim_way(input logic [1:0] valid, input logic lru);
        logic way;
        if (!valid[0]) begin
            way = WAY0;
        end else if (!valid[1]) begin
            way = WAY1;
        end else begin
            way = lru;
        end
        return way;
    endfunction

endpackage

// File: rtl/btb_set.sv
// One BTB set: two tagged entries, an LRU bit naming the next victim, and
// the hit / install-way selection logic.
module btb_set
    import btb_pkg::*;
#(
    parameter int TAG_BITS = DFLT_BTB_TAG_BITS
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                lookup_en,
    input  logic [TAG_BITS-1:0] lookup_tag,
    input  logic                upd_en,
    input  logic [TAG_BITS-1:0] upd_tag,
    input  logic [31:0]         upd_target,
    output logic                hit,
    output logic [31:0]         target
);

    logic [1:0]          valid_r;
    logic [TAG_BITS-1:0] tag_r [2];
    logic [31:0]         target_r [2];
    logic                lru_r;

    logic [1:0]          look_match_s;
    logic [1:0]          upd_match_s;
    logic                upd_way_s;

    // Tag compare for the lookup and update ports, plus install-way choice
    always_comb begin
        look_match_s[0] = valid_r[0] & (tag_r[0] == lookup_tag);
        look_match_s[1] = valid_r[1] & (tag_r[1] == lookup_tag);
        upd_match_s[0]  = valid_r[0] & (tag_r[0] == upd_tag);
        upd_match_s[1]  = valid_r[1] & (tag_r[1] == upd_tag);

        hit = lookup_en & (|look_match_s);
        if (look_match_s[0]) begin
            target = target_r[0];
        end else if (look_match_s[1]) begin
            target = target_r[1];
        end else begin
            target = 32'h0000_0000;
        end

        if (upd_match_s[0]) begin
            upd_way_s = WAY0;
        end else if (upd_match_s[1]) begin
            upd_way_s = WAY1;
        end else begin
            upd_way_s = victim_way(valid_r, lru_r);
        end
    end

    // Entry storage and LRU; an install/refresh overrides a lookup-hit LRU touch
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_r     <= 2'b00;
            tag_r[0]    <= '0;
            tag_r[1]    <= '0;
            target_r[0] <= 32'h0000_0000;
            target_r[1] <= 32'h0000_0000;
            lru_r       <= WAY0;
        end else if (upd_en) begin
            valid_r[upd_way_s]  <= 1'b1;
            tag_r[upd_way_s]    <= upd_tag;
            target_r[upd_way_s] <= upd_target;
            lru_r               <= ~upd_way_s;
        end else if (hit) begin
            lru_r <= look_match_s[0];
        end
    end

endmodule

// File: rtl/btb.sv
// 2-way set-associative branch target buffer with same-cycle lookup,
// install/refresh from execute, update-to-lookup bypass and saturating stats.
module btb
    import btb_pkg::*;
#(
    parameter int BTB_SETS     = DFLT_BTB_SETS,
    parameter int BTB_TAG_BITS = DFLT_BTB_TAG_BITS,
    parameter int STAT_BITS    = DFLT_STAT_BITS
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 lookup_valid,
    input  logic [31:0]          lookup_pc,
    output logic                 lookup_hit,
    output logic [31:0]          lookup_target,
    input  logic                 upd_valid,
    input  logic [31:0]          upd_pc,
    input  logic [31:0]          upd_target,
    input  logic                 upd_taken,
    output logic [STAT_BITS-1:0] stat_lookups,
    output logic [STAT_BITS-1:0] stat_hits
);

    localparam int IDX_BITS = $clog2(BTB_SETS);
    localparam int TAG_LSB  = 2 + IDX_BITS;
    localparam int TAG_END  = TAG_LSB + BTB_TAG_BITS;

    logic [IDX_BITS-1:0]     lookup_idx_s;
    logic [IDX_BITS-1:0]     upd_idx_s;
    logic [BTB_TAG_BITS-1:0] lookup_tag_s;
    logic [BTB_TAG_BITS-1:0] upd_tag_s;
    logic                    upd_install_s;
    logic                    bypass_s;
    logic                    hit_s;
    logic [31:0]             target_s;
    logic [BTB_SETS-1:0]     set_hit_s;
    logic [31:0]             set_target_s [BTB_SETS];
    logic [STAT_BITS-1:0]    stat_lookups_r;
    logic [STAT_BITS-1:0]    stat_hits_r;
    logic                    unused_pc_bits_s;

    assign lookup_idx_s  = lookup_pc[2 +: IDX_BITS];
    assign lookup_tag_s  = lookup_pc[TAG_LSB +: BTB_TAG_BITS];
    assign upd_idx_s     = upd_pc[2 +: IDX_BITS];
    assign upd_tag_s     = upd_pc[TAG_LSB +: BTB_TAG_BITS];
    assign upd_install_s = upd_valid & upd_taken;

    // Byte offset and bits above the partial tag never take part in matching.
    assign unused_pc_bits_s = ^{lookup_pc[1:0], lookup_pc[31:TAG_END],
                                upd_pc[1:0], upd_pc[31:TAG_END]};

    for (genvar g = 0; g < BTB_SETS; g++) begin : g_set
        btb_set #(
            .TAG_BITS(BTB_TAG_BITS)
        ) u_set (
            .clock      (clock),
            .reset      (reset),
            .lookup_en  (lookup_valid & (lookup_idx_s == IDX_BITS'(g))),
            .lookup_tag (lookup_tag_s),
            .upd_en     (upd_install_s & (upd_idx_s == IDX_BITS'(g))),
            .upd_tag    (upd_tag_s),
            .upd_target (upd_target),
            .hit        (set_hit_s[g]),
            .target     (set_target_s[g])
        );
    end

    // Lookup result: reset forces zero, then bypass, then stored entry
    always_comb begin
        bypass_s = lookup_valid & upd_install_s &
                   (lookup_idx_s == upd_idx_s) & (lookup_tag_s == upd_tag_s);
        if (!reset) begin
            hit_s    = 1'b0;
            target_s = 32'h0000_0000;
        end else if (bypass_s) begin
            hit_s    = 1'b1;
            target_s = upd_target;
        end else if (set_hit_s[lookup_idx_s]) begin
            hit_s    = 1'b1;
            target_s = set_target_s[lookup_idx_s];
        end else begin
            hit_s    = 1'b0;
            target_s = 32'h0000_0000;
        end
    end

    assign lookup_hit    = hit_s;
    assign lookup_target = target_s;

    // Saturating lookup and hit counters
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_lookups_r <= '0;
            stat_hits_r    <= '0;
        end else begin
            if (lookup_valid && (stat_lookups_r != {STAT_BITS{1'b1}})) begin
                stat_lookups_r <= stat_lookups_r + STAT_BITS'(1);
            end
            if (hit_s && (stat_hits_r != {STAT_BITS{1'b1}})) begin
                stat_hits_r <= stat_hits_r + STAT_BITS'(1);
            end
        end
    end

    assign stat_lookups = stat_lookups_r;
    assign stat_hits    = stat_hits_r;

endmodule

// File: doc/btb.md
Name: btb

Overview:
- Branch target buffer, 2-way set-associative; sits beside the local-history direction predictor in the fetch stage.
- Fetch presents its PC each cycle and gets a same-cycle hit/target.
- Fetch combines that target with the predictor's taken bit to choose the next PC.
- Resolved taken branches from execute install or refresh entries; per-set LRU picks the victim.

Parameters:
- BTB_SETS, 16, number of sets (power of two, ≥2).
- BTB_TAG_BITS, 10, partial tag width taken from the PC above the index.
- STAT_BITS, 16, width of the saturating lookup/hit statistics counters.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- lookup_valid  in  1  fetch PC valid this cycle.
- lookup_pc  in  32  fetch PC.
- lookup_hit  out  1  tag match in a valid way (or bypass hit).
- lookup_target  out  32  predicted target; 0 when lookup_hit=0.
- upd_valid  in  1  resolved branch from execute.
- upd_pc  in  32  branch PC.
- upd_target  in  32  resolved target.
- upd_taken  in  1  branch resolved taken.
- stat_lookups  out  STAT_BITS  count of valid lookups.
- stat_hits  out  STAT_BITS  count of valid lookups that hit.

Behaviour:
- Addressing:
  - idx = pc[2 +: log2(BTB_SETS)].
  - tag = pc[2+log2(BTB_SETS) +: BTB_TAG_BITS].
  - pc[1:0] ignored.
- Entry contents: {valid, tag, target[31:0]}. Per-set state: lru bit giving the way to evict next.
- Reset (reset=0, asynchronous): all valid bits, lru bits and stat counters clear; outputs go to 0 immediately. Target/tag storage need not be cleared. Reset may be asserted mid-operation with no further requirement.
- Lookup (combinational, 0-cycle latency):
  - lookup_hit = lookup_valid & (way0 or way1 valid with matching tag).
  - lookup_target = the matching way's target.
  - Both ways matching is not allowed; the update rule prevents it. If it ever happens, way0 wins.
  - lookup_valid=0 forces lookup_hit=0 and lookup_target=0.
- Update, applied on the next rising clock edge when upd_valid=1:
  - upd_taken=1 and tag hits in a way: overwrite that way's target; that way becomes MRU.
  - upd_taken=1 and tag misses: victim is the first invalid way (way0 before way1), else the lru way. Write valid=1, tag, target; victim becomes MRU.
  - upd_taken=0: no storage or LRU change. Entries are never removed by not-taken outcomes.
- LRU on lookup hit: the hitting way becomes MRU at the edge.
  - If an update touches the same set in the same cycle, the update's LRU write wins.
- Same-cycle bypass: upd_valid & upd_taken & (upd idx,tag == lookup idx,tag) with lookup_valid=1:
  - lookup_hit=1 and lookup_target=upd_target, regardless of stored contents.
  - This counts as a hit for statistics.
- Statistics:
  - stat_lookups increments on each lookup_valid cycle.
  - stat_hits increments on each cycle with lookup_hit=1.
  - Both saturate at all-ones; they never wrap.
- Aliasing: the tag is partial, so PCs differing only above the tag field alias. This is allowed; fetch validates the target downstream.

Decomposition:
- Shared package in sys_defs:
  - BTB_SETS, BTB_TAG_BITS, BTB_IDX_BITS as macros.
  - BTB_ENTRY struct {valid, tag, target}.
  - BTB_DEBUG struct (entries, lru) for the DEBUG-only output port, following the existing debug-port convention.
- Sub-module: btb_set (one set: two entries, lru bit, hit/victim logic), instantiated BTB_SETS times.

Test Plan:
- Reset, then lookup_pc=0x1000 -> lookup_hit=0, lookup_target=0, stat_lookups=1, stat_hits=0.
- Update {pc=0x1000, target=0x2000, taken=1}; next cycle lookup 0x1000 -> hit=1, target=0x2000; lookup 0x1004 -> hit=0.
- Fill the same set (BTB_SETS=16) at 0x1000 then 0x1040, lookup 0x1000, then install 0x1080 -> 0x1040 evicted (miss), 0x1000 and 0x1080 hit.
- Same-cycle update {0x3000->0x4000, taken=1} with lookup 0x3000 -> hit=1, target=0x4000 that cycle, stat_hits increments.
- Update {0x1000, target=0x5000, taken=0} on an existing entry -> lookup still returns 0x2000; LRU unchanged.
- Hold lookup_valid for 2^STAT_BITS+5 cycles -> stat_lookups stays at 0xFFFF; assert reset=0 mid-run -> all outputs 0 immediately.
